// File: rtl/mc_control_fsm_if.sv
// Memory-port handshake between the control FSM (master) and the unified memory (slave).
interface mc_control_fsm_if;
  logic req;      // request valid
  logic we;       // request is a write
  logic adr_src;  // 0: address = PC, 1: address = ALUOut
  logic ready;    // memory completes the current request this cycle

  modport master (
    output req,
    output we,
    output adr_src,
    input  ready
  );

  modport slave (
    input  req,
    input  we,
    input  adr_src,
    output ready
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences the shared ALU, unified memory port and datapath
// registers, decoding opcode/funct3 into per-state selects, write enables and imm type.

typedef enum logic [2:0] {
  IMM_I = 3'd0,
  IMM_S = 3'd1,
  IMM_B = 3'd2,
  IMM_U = 3'd3,
  IMM_J = 3'd4
} imm_src_t;

module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [6:0]              i_op,
  input  logic [2:0]              i_funct3,
  input  logic                    i_zero,
  input  logic                    i_lt,
  input  logic                    i_ltu,
  mc_control_fsm_if.master        mem,
  output logic                    o_ir_write,
  output logic                    o_pc_write,
  output logic                    o_reg_write,
  output logic [1:0]              o_result_src,
  output logic [1:0]              o_alu_src_a,
  output logic [1:0]              o_alu_src_b,
  output logic [1:0]              o_alu_op,
  output imm_src_t                o_imm_src,
  output logic                    o_fault,
  output logic [3:0]              o_state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned    CntW    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBranch, StJal, StJalr, StLink, StLui, StTrap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            taken, bad_branch, limit;
  logic            mem_req, mem_we, adr_src;

  assign limit = (MEM_TIMEOUT != 0) && (cnt_q == CntLast);

  // Branch condition from funct3; 010/011 are not valid branch encodings.
  always_comb begin
    taken      = 1'b0;
    bad_branch = 1'b0;
    case (i_funct3)
      3'b000:  taken = i_zero;
      3'b001:  taken = ~i_zero;
      3'b100:  taken = i_lt;
      3'b101:  taken = ~i_lt;
      3'b110:  taken = i_ltu;
      3'b111:  taken = ~i_ltu;
      default: bad_branch = 1'b1;
    endcase
  end

  // Next state, per-state controls (pc/ir write are Mealy) and the wait counter.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    adr_src      = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_result_src = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_imm_src    = IMM_I;
    o_fault      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req      = 1'b1;
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        if (mem.ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          state_d    = StDecode;
        end else if (limit) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        case (i_op)
          OpStore:         o_imm_src = IMM_S;
          OpBranch:        o_imm_src = IMM_B;
          OpJal:           o_imm_src = IMM_J;
          OpLui, OpAuipc:  o_imm_src = IMM_U;
          default:         o_imm_src = IMM_I;
        endcase
        case (i_op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAluWb;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_imm_src   = (i_op == OpStore) ? IMM_S : IMM_I;
        state_d     = (i_op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem.ready)  state_d = StMemWb;
        else if (limit) state_d = StTrap;
      end
      StMemWb: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem.ready)  state_d = StFetch;
        else if (limit) state_d = StTrap;
      end
      StExecR: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b10;
        state_d     = StAluWb;
      end
      StExecI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
        state_d     = StAluWb;
      end
      StAluWb: begin
        o_reg_write = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        if (bad_branch) begin
          state_d = StTrap;
        end else begin
          o_pc_write = taken;
          state_d    = StFetch;
        end
      end
      StJal: begin
        // PC <= target on the result bus while the ALU forms oldPC+4 for the link.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
        state_d     = StAluWb;
      end
      StJalr: begin
        o_alu_src_a  = 2'b10;
        o_alu_src_b  = 2'b01;
        o_result_src = 2'b10;
        o_pc_write   = 1'b1;
        state_d      = StLink;
      end
      StLink: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        state_d     = StAluWb;
      end
      StLui: begin
        o_imm_src    = IMM_U;
        o_result_src = 2'b11;
        o_reg_write  = 1'b1;
        state_d      = StFetch;
      end
      StTrap: o_fault = 1'b1;
    endcase
    cnt_d = (mem_req && !mem.ready) ? cnt_q + CntW'(1) : '0;
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem.req     = mem_req;
  assign mem.we      = mem_we;
  assign mem.adr_src = adr_src;
  assign o_state     = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with a short memory timeout (4 wait cycles).
module tb_mc_control_fsm;

  localparam int StIdle = 0, StFetch = 1, StDecode = 2, StMemAdr = 3, StMemRead = 4;
  localparam int StMemWb = 5, StMemWrite = 6, StExecI = 8, StAluWb = 9, StBranch = 10;
  localparam int StJal = 11, StJalr = 12, StLink = 13, StLui = 14, StTrap = 15;
  localparam int ImmI = 0, ImmS = 1, ImmB = 2, ImmU = 3, ImmJ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op;
  logic [2:0] f3;
  logic       zero, lt, ltu;
  logic       ir_write, pc_write, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  int         n_vec = 0;
  int         n_err = 0;

  mc_control_fsm_if mem ();

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_op        (op),
    .i_funct3    (f3),
    .i_zero      (zero),
    .i_lt        (lt),
    .i_ltu       (ltu),
    .mem         (mem),
    .o_ir_write  (ir_write),
    .o_pc_write  (pc_write),
    .o_reg_write (reg_write),
    .o_result_src(result_src),
    .o_alu_src_a (alu_src_a),
    .o_alu_src_b (alu_src_b),
    .o_alu_op    (alu_op),
    .o_imm_src   (imm_src),
    .o_fault     (fault),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  // Packed expectation: {fault, req, we, adr, ir_w, pc_w, reg_w, res, a, b, op, imm, state}.
  function automatic logic [21:0] ev(input int st, input int flt, input int req, input int we,
                                     input int adr, input int irw, input int pcw, input int rw,
                                     input int res, input int a, input int b, input int aop,
                                     input int imm);
    return {flt[0], req[0], we[0], adr[0], irw[0], pcw[0], rw[0], res[1:0], a[1:0], b[1:0],
            aop[1:0], imm[2:0], st[3:0]};
  endfunction

  function automatic logic [21:0] fetch(input int rdy);
    return ev(StFetch, 0, 1, 0, 0, rdy, rdy, 0, 2, 0, 2, 0, ImmI);
  endfunction

  function automatic logic [21:0] dec(input int imm);
    return ev(StDecode, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, imm);
  endfunction

  function automatic logic [21:0] aluwb();
    return ev(StAluWb, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ImmI);
  endfunction

  function automatic logic [21:0] branch(input int pcw);
    return ev(StBranch, 0, 0, 0, 0, 0, pcw, 0, 0, 2, 0, 1, ImmI);
  endfunction

  function automatic logic [21:0] trap();
    return ev(StTrap, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ImmI);
  endfunction

  task automatic chk(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {fault, mem.req, mem.we, mem.adr_src, ir_write, pc_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, state};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check 1 ns later.
  task automatic cyc(input string tag, input logic [2:0] flg, input logic rdy,
                     input logic [21:0] exp);
    @(negedge clk);
    op = cur_op;
    f3 = cur_f3;
    {zero, lt, ltu} = flg;
    mem.ready = rdy;
    #1;
    chk(tag, exp);
  endtask

  // Re-check within the same cycle after changing only the ALU flags.
  task automatic peek(input string tag, input logic [2:0] flg, input logic [21:0] exp);
    {zero, lt, ltu} = flg;
    #1;
    chk(tag, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_pulse", '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_idle", '0);
  endtask

  initial begin
    cur_op = 7'd0;
    cur_f3 = 3'd0;
    op = 7'd0;
    f3 = 3'd0;
    {zero, lt, ltu} = 3'b000;
    mem.ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle", '0);

    // ADDI
    cur_op = 7'b0010011;
    cyc("addi_fetch", 3'b000, 1'b1, fetch(1));
    cyc("addi_decode", 3'b000, 1'b1, dec(ImmI));
    cyc("addi_exec", 3'b000, 1'b1, ev(StExecI, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, ImmI));
    cyc("addi_wb", 3'b000, 1'b1, aluwb());

    // LW with ready three cycles late (ready on the timeout limit wins)
    cur_op = 7'b0000011;
    cyc("lw_fetch", 3'b000, 1'b1, fetch(1));
    cyc("lw_decode", 3'b000, 1'b1, dec(ImmI));
    cyc("lw_memadr", 3'b000, 1'b1, ev(StMemAdr, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, ImmI));
    for (int i = 0; i < 3; i++)
      cyc("lw_wait", 3'b000, 1'b0, ev(StMemRead, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ImmI));
    cyc("lw_ready", 3'b000, 1'b1, ev(StMemRead, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ImmI));
    cyc("lw_wb", 3'b000, 1'b1, ev(StMemWb, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ImmI));

    // BNE: zero=1 not taken, zero=0 taken
    cur_op = 7'b1100011;
    cur_f3 = 3'b001;
    cyc("bne_fetch", 3'b000, 1'b1, fetch(1));
    cyc("bne_decode", 3'b000, 1'b1, dec(ImmB));
    cyc("bne_eq", 3'b100, 1'b1, branch(0));
    peek("bne_ne", 3'b000, branch(1));

    // BLTU follows i_ltu, not i_lt
    cur_f3 = 3'b110;
    cyc("bltu_fetch", 3'b000, 1'b1, fetch(1));
    cyc("bltu_decode", 3'b000, 1'b1, dec(ImmB));
    cyc("bltu_lt_only", 3'b010, 1'b1, branch(0));
    peek("bltu_ltu", 3'b001, branch(1));

    // JAL
    cur_op = 7'b1101111;
    cur_f3 = 3'b000;
    cyc("jal_fetch", 3'b000, 1'b1, fetch(1));
    cyc("jal_decode", 3'b000, 1'b1, dec(ImmJ));
    cyc("jal_exec", 3'b000, 1'b1, ev(StJal, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0, ImmI));
    cyc("jal_wb", 3'b000, 1'b1, aluwb());

    // JALR
    cur_op = 7'b1100111;
    cyc("jalr_fetch", 3'b000, 1'b1, fetch(1));
    cyc("jalr_decode", 3'b000, 1'b1, dec(ImmI));
    cyc("jalr_exec", 3'b000, 1'b1, ev(StJalr, 0, 0, 0, 0, 0, 1, 0, 2, 2, 1, 0, ImmI));
    cyc("jalr_link", 3'b000, 1'b1, ev(StLink, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ImmI));
    cyc("jalr_wb", 3'b000, 1'b1, aluwb());

    // LUI
    cur_op = 7'b0110111;
    cyc("lui_fetch", 3'b000, 1'b1, fetch(1));
    cyc("lui_decode", 3'b000, 1'b1, dec(ImmU));
    cyc("lui_wb", 3'b000, 1'b1, ev(StLui, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, ImmU));

    // SW, reset asserted while the write waits
    cur_op = 7'b0100011;
    cur_f3 = 3'b010;
    cyc("sw_fetch", 3'b000, 1'b1, fetch(1));
    cyc("sw_decode", 3'b000, 1'b1, dec(ImmS));
    cyc("sw_memadr", 3'b000, 1'b1, ev(StMemAdr, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, ImmS));
    cyc("sw_wait0", 3'b000, 1'b0, ev(StMemWrite, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ImmI));
    cyc("sw_wait1", 3'b000, 1'b0, ev(StMemWrite, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ImmI));
    rst = 1'b1;
    #1;
    chk("sw_async_rst", '0);
    cyc("rst_hold", 3'b000, 1'b1, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release", '0);

    // Fetch timeout: four wait cycles, then sticky TRAP
    cur_op = 7'b0010011;
    cur_f3 = 3'b000;
    for (int i = 0; i < 4; i++) cyc("to_wait", 3'b000, 1'b0, fetch(0));
    cyc("to_trap", 3'b000, 1'b0, trap());
    cyc("trap_sticky", 3'b000, 1'b1, trap());

    // Illegal opcode
    pulse_reset();
    cur_op = 7'b0000000;
    cyc("ill_fetch", 3'b000, 1'b1, fetch(1));
    cyc("ill_decode", 3'b000, 1'b1, dec(ImmI));
    cyc("ill_trap", 3'b000, 1'b1, trap());

    // Branch funct3=010 is invalid: no pc_write, then TRAP
    pulse_reset();
    cur_op = 7'b1100011;
    cur_f3 = 3'b010;
    cyc("br010_fetch", 3'b000, 1'b1, fetch(1));
    cyc("br010_decode", 3'b000, 1'b1, dec(ImmB));
    cyc("br010_branch", 3'b100, 1'b1, branch(0));
    cyc("br010_trap", 3'b000, 1'b1, trap());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
